// File: rtl/run_monitor_pkg.sv
// Shared types for the run monitor: output item kinds and FSM states.
// Imported by the run monitor top level.
package run_monitor_pkg;

    typedef enum logic [1:0] {
        KIND_PC  = 2'd0,
        KIND_REG = 2'd1,
        KIND_MEM = 2'd2,
        KIND_END = 2'd3
    } kind_e;

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_DRAIN = 3'd1,
        ST_REGS  = 3'd2,
        ST_MEMS  = 3'd3,
        ST_FIN   = 3'd4,
        ST_IDLE  = 3'd5
    } state_e;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with registered read data for the PC trace.
// DEPTH must be a power of two of at least 2.
module trace_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q;
    logic [AW:0]  rptr_q;
    logic [W-1:0] rdata_q;

    // Extra pointer bit tells full from empty when the indices match.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata_o = rdata_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            rdata_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wptr_q[AW-1:0]] <= wdata_i;
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop_i) begin
                rdata_q <= mem_q[rptr_q[AW-1:0]];
                rptr_q  <= rptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/run_monitor.sv
// Run monitor: traces PCs until halt, then streams trace, registers,
// a data-memory window and an END marker over a ready/valid port.
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int unsigned MAX_CYCLES  = 64,
    parameter int unsigned TRACE_DEPTH = 64,
    parameter logic [31:0] MEM_BASE    = 32'h4000,
    parameter int unsigned MEM_COUNT   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    output logic [4:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic [31:0] mem_raddr,
    input  logic [7:0]  mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  out_kind,
    output logic [31:0] out_data,
    output logic        overflow,
    output logic        done
);
    state_e      state_q;
    kind_e       kind_q;
    logic        valid_q;
    logic [31:0] data_q;
    logic [31:0] cyc_q;
    logic [4:0]  reg_idx_q;
    logic [31:0] mem_idx_q;
    logic        ovf_q;
    logic        done_q;

    logic        load;
    logic        halt;
    logic        pop;
    logic        push;
    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] fifo_rdata;

    always_comb begin
        load = !valid_q || out_ready;
        halt = (inst == '0) || (cyc_q == 32'(MAX_CYCLES - 1));
        pop  = 1'b0;
        if (!fifo_empty) begin
            pop = (state_q == ST_RUN   && out_ready) ||
                  (state_q == ST_DRAIN && load);
        end
        push = (state_q == ST_RUN) && (!fifo_full || pop);
    end

    trace_fifo #(
        .W     (32),
        .DEPTH (TRACE_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (push),
        .wdata_i (pc),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            kind_q    <= KIND_PC;
            valid_q   <= 1'b0;
            data_q    <= '0;
            cyc_q     <= '0;
            reg_idx_q <= '0;
            mem_idx_q <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (fifo_full && !pop) ovf_q <= 1'b1;
                    if (out_ready) begin
                        valid_q <= pop;
                        if (pop) kind_q <= KIND_PC;
                    end
                    if (halt) state_q <= ST_DRAIN;
                    else if (cyc_q != '1) cyc_q <= cyc_q + 1'b1;
                end
                ST_DRAIN: begin
                    if (load) begin
                        valid_q <= pop;
                        kind_q  <= KIND_PC;
                        if (fifo_empty) state_q <= ST_REGS;
                    end
                end
                ST_REGS: begin
                    if (load) begin
                        valid_q   <= 1'b1;
                        kind_q    <= KIND_REG;
                        data_q    <= rf_rdata;
                        reg_idx_q <= reg_idx_q + 1'b1;
                        if (reg_idx_q == 5'd31) state_q <= ST_MEMS;
                    end
                end
                ST_MEMS: begin
                    if (load) begin
                        valid_q   <= 1'b1;
                        kind_q    <= KIND_MEM;
                        data_q    <= {24'b0, mem_rdata};
                        mem_idx_q <= mem_idx_q + 1'b1;
                        if (mem_idx_q == 32'(MEM_COUNT - 1)) state_q <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    // END stays in the register until the collector takes it.
                    if (valid_q && kind_q == KIND_END) begin
                        if (out_ready) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end else if (load) begin
                        valid_q <= 1'b1;
                        kind_q  <= KIND_END;
                        data_q  <= cyc_q;
                    end
                end
                ST_IDLE: begin
                    valid_q <= 1'b0;
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    // PC payloads live in the FIFO read register; it only moves on a pop.
    assign out_data  = (kind_q == KIND_PC) ? fifo_rdata : data_q;
    assign out_valid = valid_q;
    assign out_kind  = kind_q;
    assign overflow  = ovf_q;
    assign done      = done_q;
    assign rf_raddr  = reg_idx_q;
    assign mem_raddr = MEM_BASE + mem_idx_q;

endmodule

// File: tb/tb_run_monitor.sv
// Randomized bench for run_monitor against a stream-level model.
// Expected stream: kept PCs, 32 regs, memory window, END cycle count.
module tb_run_monitor;
    import run_monitor_pkg::*;

    localparam int          MAXC  = 64;
    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h4000;
    localparam int          MCNT  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic [31:0] mem_raddr;
    logic [7:0]  mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_kind;
    logic [31:0] out_data;
    logic        overflow;
    logic        done;

    int total = 0;
    int bad   = 0;

    logic [31:0] rf_mem [32];
    logic [7:0]  dmem [MCNT];

    always #5 clk = ~clk;

    run_monitor #(
        .MAX_CYCLES  (MAXC),
        .TRACE_DEPTH (DEPTH),
        .MEM_BASE    (BASE),
        .MEM_COUNT   (MCNT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .inst      (inst),
        .rf_raddr  (rf_raddr),
        .rf_rdata  (rf_rdata),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_kind  (out_kind),
        .out_data  (out_data),
        .overflow  (overflow),
        .done      (done)
    );

    assign rf_rdata = rf_mem[rf_raddr];

    always_comb begin
        mem_rdata = 8'hEE;
        for (int i = 0; i < MCNT; i++)
            if (mem_raddr == BASE + 32'(i)) mem_rdata = dmem[i];
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 32; i++) rf_mem[i] = $urandom();
        for (int i = 0; i < MCNT; i++) dmem[i] = 8'($urandom());
    endtask

    task automatic do_reset();
        reset = 1'b1;
        out_ready = 1'b0;
        pc = '0;
        inst = 32'h13;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_kind", 32'(out_kind), 0);
        check("rst_data", out_data, 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_done", 32'(done), 0);
        check("rst_raddr", 32'(rf_raddr), 0);
        check("rst_maddr", mem_raddr, BASE);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // rpol: 0 ready, 1 stalled, 2 random (h < DEPTH), 3 stalled DEPTH cycles.
    // dpol: 0 ready, 1 toggling, 2 random.
    task automatic run_case(input int h, input int rpol, input int dpol,
                            input bit seq, input bit abort);
        logic [31:0] pcs [MAXC];
        logic [1:0]  ek [$];
        logic [31:0] ed [$];
        logic [1:0]  hk;
        logic [31:0] hd;
        int  keep;
        int  c;
        int  limit;
        bit  eovf;
        bit  stall;
        bit  got_end;
        bit  abort_now;

        for (int i = 0; i < MAXC; i++)
            pcs[i] = seq ? 32'(i * 4) : ($urandom() & 32'hFFFF_FFFC);
        keep = h + 1;
        eovf = 1'b0;
        if (rpol == 1 && keep > DEPTH) begin
            keep = DEPTH;
            eovf = 1'b1;
        end
        for (int i = 0; i < keep; i++) begin
            ek.push_back(KIND_PC); ed.push_back(pcs[i]);
        end
        for (int i = 0; i < 32; i++) begin
            ek.push_back(KIND_REG); ed.push_back(rf_mem[i]);
        end
        for (int i = 0; i < MCNT; i++) begin
            ek.push_back(KIND_MEM); ed.push_back({24'b0, dmem[i]});
        end
        ek.push_back(KIND_END); ed.push_back(32'(h));

        do_reset();
        c = 0; stall = 0; got_end = 0; abort_now = 0;
        hk = '0; hd = '0;
        limit = h + 300;
        while (!got_end && c < limit) begin
            if (c < h) begin
                pc = pcs[c];
                inst = $urandom() | 32'h1;
            end else if (c == h) begin
                pc = pcs[c];
                inst = (h < MAXC - 1) ? 32'h0 : ($urandom() | 32'h1);
            end else begin
                pc = $urandom();
                inst = $urandom();
            end
            if (c <= h) begin
                case (rpol)
                    0: out_ready = 1'b1;
                    1: out_ready = 1'b0;
                    2: out_ready = 1'($urandom_range(0, 1));
                    default: out_ready = (c >= DEPTH);
                endcase
            end else begin
                case (dpol)
                    0: out_ready = 1'b1;
                    1: out_ready = (c % 2 == 0);
                    default: out_ready = 1'($urandom_range(0, 1));
                endcase
            end
            @(negedge clk);
            if (stall) begin
                check("hold_valid", 32'(out_valid), 1);
                check("hold_kind", 32'(out_kind), 32'(hk));
                check("hold_data", out_data, hd);
            end
            if (out_valid && out_ready) begin
                check("stream_len", 32'(ek.size() > 0), 1);
                if (ek.size() > 0) begin
                    check("kind", 32'(out_kind), 32'(ek[0]));
                    check("data", out_data, ed[0]);
                    void'(ek.pop_front());
                    void'(ed.pop_front());
                end
                if (out_kind == KIND_END) got_end = 1'b1;
            end
            stall = out_valid && !out_ready;
            hk = out_kind;
            hd = out_data;
            if (abort && rf_raddr == 5'd10) abort_now = 1'b1;
            @(posedge clk);
            #1;
            c++;
            if (abort_now) begin
                reset = 1'b1;
                @(posedge clk);
                #1;
                reset = 1'b0;
                out_ready = 1'b0;
                @(negedge clk);
                check("abort_valid", 32'(out_valid), 0);
                check("abort_raddr", 32'(rf_raddr), 0);
                check("abort_maddr", mem_raddr, BASE);
                check("abort_done", 32'(done), 0);
                return;
            end
        end
        check("end_seen", 32'(got_end), 1);
        @(negedge clk);
        check("done", 32'(done), 1);
        check("left_items", 32'(ek.size()), 0);
        check("overflow", 32'(overflow), 32'(eovf));
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            out_ready = 1'($urandom_range(0, 1));
            inst = $urandom();
            @(negedge clk);
            check("idle_valid", 32'(out_valid), 0);
            check("idle_done", 32'(done), 1);
        end
    endtask

    initial begin
        int h;
        int rp;
        reset = 1'b1;
        out_ready = 1'b0;
        pc = '0;
        inst = '0;

        fill_mem();
        rf_mem[2] = 32'h1;
        rf_mem[3] = 32'h0040_0000;
        run_case(2, 0, 0, 1'b1, 1'b0);
        fill_mem();
        run_case(MAXC - 1, 0, 0, 1'b1, 1'b0);
        run_case(19, 1, 0, 1'b1, 1'b0);
        run_case(10, 0, 1, 1'b1, 1'b0);
        run_case(5, 0, 1, 1'b1, 1'b1);
        run_case(5, 0, 0, 1'b1, 1'b0);
        run_case(0, 0, 0, 1'b1, 1'b0);
        run_case(15, 3, 2, 1'b0, 1'b0);

        for (int n = 0; n < 20; n++) begin
            fill_mem();
            h  = $urandom_range(0, MAXC - 1);
            rp = $urandom_range(0, 3);
            if (rp == 2 && h >= DEPTH) h = $urandom_range(0, DEPTH - 1);
            run_case(h, rp, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                     1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
